// File: rtl/lcd_line_fetch_pkg.sv
// Shared types for the LCD line-prefetch DMA.
// Fetch FSM encoding and RGB565 field layout.
package lcd_line_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_LO,
        S_WAIT_HI,
        S_WR,
        S_DONE
    } fetch_state_t;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    function automatic logic [4:0] rgb565_r(input logic [15:0] px);
        return px[RGB_R_MSB:RGB_R_LSB];
    endfunction

    function automatic logic [5:0] rgb565_g(input logic [15:0] px);
        return px[RGB_G_MSB:RGB_G_LSB];
    endfunction

    function automatic logic [4:0] rgb565_b(input logic [15:0] px);
        return px[RGB_B_MSB:RGB_B_LSB];
    endfunction

endpackage

// File: rtl/lcd_fb_addr_gen.sv
// Line/word counters and framebuffer address generator.
// o_addr_nxt is the address of the word the counter moves to this cycle.
module lcd_fb_addr_gen #(
    parameter logic [31:0] FB_BASE = 32'h0000_0000,
    parameter int          WIDTH   = 1024,
    parameter int          HEIGHT  = 600,
    parameter int          LB_AW   = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_clr,
    input  logic             i_line_inc,
    input  logic             i_word_clr,
    input  logic             i_word_inc,
    output logic [LB_AW-1:0] o_word,
    output logic             o_last_word,
    output logic [31:0]      o_addr_nxt
);

    localparam int LN_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [LB_AW-1:0] LAST_WORD  = LB_AW'(WIDTH / 2 - 1);
    localparam logic [LN_W-1:0]  LAST_LINE  = LN_W'(HEIGHT - 1);
    localparam logic [31:0]      LINE_BYTES = 32'(WIDTH * 2);

    logic [LN_W-1:0]  r_line;
    logic [LB_AW-1:0] r_word;
    logic [LB_AW-1:0] w_word_nxt;

    // Next word index: cleared at line start, stepped after each write.
    always_comb begin
        w_word_nxt = r_word;
        if (i_word_clr) begin
            w_word_nxt = '0;
        end else if (i_word_inc) begin
            w_word_nxt = r_word + 1'b1;
        end
    end

    // Line counter wraps at the bottom of the frame; word follows w_word_nxt.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line <= '0;
            r_word <= '0;
        end else begin
            r_word <= w_word_nxt;
            if (i_frame_clr) begin
                r_line <= '0;
            end else if (i_line_inc) begin
                r_line <= (r_line == LAST_LINE) ? '0 : r_line + 1'b1;
            end
        end
    end

    assign o_word      = r_word;
    assign o_last_word = (r_word == LAST_WORD);
    assign o_addr_nxt  = FB_BASE + 32'(r_line) * LINE_BYTES
                       + (32'(w_word_nxt) << 2);

endmodule

// File: rtl/lcd_line_fetch.sv
// PSRAM-to-line-buffer prefetch DMA for the LCD timing generator.
// One read per word; completion is ready going low then high again.
module lcd_line_fetch
    import lcd_line_fetch_pkg::*;
#(
    parameter logic [31:0] FB_BASE = 32'h0000_0000,
    parameter int          WIDTH   = 1024,
    parameter int          HEIGHT  = 600,
    parameter int          LB_AW   = 9
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             frame_start,
    input  logic             line_req,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic             lb_we,
    output logic [LB_AW:0]   lb_waddr,
    output logic [31:0]      lb_wdata,
    output logic             busy,
    output logic             line_done,
    output logic             cur_bank,
    output logic             overrun
);

    fetch_state_t     r_state;
    logic             r_abort;
    logic             r_wr_bank;
    logic             r_mem_valid;
    logic [31:0]      r_mem_addr;
    logic             r_lb_we;
    logic [LB_AW:0]   r_lb_waddr;
    logic [31:0]      r_lb_wdata;
    logic             r_busy;
    logic             r_line_done;
    logic             r_cur_bank;
    logic             r_overrun;

    logic             w_abort;
    logic             w_start;
    logic             w_next;
    logic             w_frame_clr;
    logic             w_line_inc;
    logic             w_last;
    logic [LB_AW-1:0] w_word;
    logic [31:0]      w_addr_nxt;

    assign w_abort     = r_abort | frame_start;
    assign w_start     = (r_state == S_IDLE) & line_req & ~frame_start;
    assign w_next      = (r_state == S_WR) & ~w_abort & ~w_last;
    assign w_line_inc  = (r_state == S_DONE) & ~frame_start;
    assign w_frame_clr = ((r_state == S_IDLE) & frame_start)
                       | ((r_state == S_WR) & w_abort)
                       | ((r_state == S_DONE) & frame_start);

    lcd_fb_addr_gen #(
        .FB_BASE (FB_BASE),
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .LB_AW   (LB_AW)
    ) u_addr (
        .i_clk       (CLK),
        .i_rst_n     (nRST),
        .i_frame_clr (w_frame_clr),
        .i_line_inc  (w_line_inc),
        .i_word_clr  (w_start),
        .i_word_inc  (w_next),
        .o_word      (w_word),
        .o_last_word (w_last),
        .o_addr_nxt  (w_addr_nxt)
    );

    // Handshake FSM with all outputs registered; later assignments win.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_IDLE;
            r_abort     <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_lb_we     <= 1'b0;
            r_lb_waddr  <= '0;
            r_lb_wdata  <= '0;
            r_busy      <= 1'b0;
            r_line_done <= 1'b0;
            r_cur_bank  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mem_valid <= 1'b0;
            r_lb_we     <= 1'b0;
            r_line_done <= 1'b0;
            if (line_req && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_wr_bank  <= 1'b0;
                        r_cur_bank <= 1'b0;
                        r_overrun  <= 1'b0;
                    end else if (line_req) begin
                        r_busy      <= 1'b1;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= w_addr_nxt;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (frame_start) r_abort <= 1'b1;
                    r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (frame_start) r_abort <= 1'b1;
                    if (!mem_ready) r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (frame_start) r_abort <= 1'b1;
                    if (mem_ready) begin
                        if (!w_abort) begin
                            r_lb_we    <= 1'b1;
                            r_lb_waddr <= {r_wr_bank, w_word};
                            r_lb_wdata <= mem_rdata;
                        end
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    if (w_abort) begin
                        r_abort    <= 1'b0;
                        r_wr_bank  <= 1'b0;
                        r_cur_bank <= 1'b0;
                        r_overrun  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_last) begin
                        r_line_done <= 1'b1;
                        r_cur_bank  <= r_wr_bank;
                        r_wr_bank   <= ~r_wr_bank;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= w_addr_nxt;
                        r_state     <= S_REQ;
                    end
                end
                S_DONE: begin
                    if (frame_start) begin
                        r_wr_bank  <= 1'b0;
                        r_cur_bank <= 1'b0;
                        r_overrun  <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = 32'h0;
    assign mem_wstrb = 4'h0;
    assign lb_we     = r_lb_we;
    assign lb_waddr  = r_lb_waddr;
    assign lb_wdata  = r_lb_wdata;
    assign busy      = r_busy;
    assign line_done = r_line_done;
    assign cur_bank  = r_cur_bank;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_lcd_line_fetch.sv
// Directed bench for lcd_line_fetch: full-size instance plus a
// narrow instance used to walk a whole frame and check line wrap.
module tb_lcd_line_fetch;

    localparam logic [31:0] XORK = 32'hA5A5_A5A5;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_req = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        lb_we;
    logic [9:0]  lb_waddr;
    logic [31:0] lb_wdata;
    logic        busy;
    logic        line_done;
    logic        cur_bank;
    logic        overrun;

    logic        w_line_req = 1'b0;
    logic        w_frame_start = 1'b0;
    logic        w_mem_valid;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [3:0]  w_mem_wstrb;
    logic [31:0] w_mem_rdata;
    logic        w_mem_ready;
    logic        w_lb_we;
    logic [1:0]  w_lb_waddr;
    logic [31:0] w_lb_wdata;
    logic        w_busy;
    logic        w_line_done;
    logic        w_cur_bank;
    logic        w_overrun;

    int n_tests = 0;
    int n_fail = 0;
    int lat = 14;
    int br_err = 0;
    int br_cnt;
    logic [31:0] br_addr;
    int wb_cnt;
    logic [31:0] wb_addr;

    always #5 CLK = ~CLK;

    lcd_line_fetch dut (
        .CLK(CLK), .nRST(nRST), .frame_start(frame_start), .line_req(line_req),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .busy(busy),
        .line_done(line_done), .cur_bank(cur_bank), .overrun(overrun)
    );

    lcd_line_fetch #(.WIDTH(4), .HEIGHT(600), .LB_AW(1)) u_wrap (
        .CLK(CLK), .nRST(nRST), .frame_start(w_frame_start), .line_req(w_line_req),
        .mem_valid(w_mem_valid), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .mem_wstrb(w_mem_wstrb), .mem_rdata(w_mem_rdata), .mem_ready(w_mem_ready),
        .lb_we(w_lb_we), .lb_waddr(w_lb_waddr), .lb_wdata(w_lb_wdata), .busy(w_busy),
        .line_done(w_line_done), .cur_bank(w_cur_bank), .overrun(w_overrun)
    );

    // Bridge model: ready stays high until a valid is sampled, then low for
    // lat cycles; rdata is garbage until completion. Valid while busy = error.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mem_ready <= 1'b1;
            mem_rdata <= '0;
            br_cnt    <= 0;
            br_addr   <= '0;
        end else if (mem_valid) begin
            if (br_cnt != 0) br_err <= br_err + 1;
            mem_ready <= 1'b0;
            mem_rdata <= 32'hDEAD_BEEF;
            br_addr   <= mem_addr;
            br_cnt    <= lat;
        end else if (br_cnt != 0) begin
            br_cnt <= br_cnt - 1;
            if (br_cnt == 1) begin
                mem_ready <= 1'b1;
                mem_rdata <= br_addr ^ XORK;
            end
        end
    end

    // Single-cycle-latency bridge for the wrap instance.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            w_mem_ready <= 1'b1;
            w_mem_rdata <= '0;
            wb_cnt      <= 0;
            wb_addr     <= '0;
        end else if (w_mem_valid) begin
            w_mem_ready <= 1'b0;
            w_mem_rdata <= 32'hDEAD_BEEF;
            wb_addr     <= w_mem_addr;
            wb_cnt      <= 1;
        end else if (wb_cnt != 0) begin
            wb_cnt      <= wb_cnt - 1;
            w_mem_ready <= 1'b1;
            w_mem_rdata <= wb_addr ^ XORK;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int lat;
        bit pre_fs;
        int ovr_at;
        int abort_at;
        int line;
        bit bank;
        bit exp_cb;
        bit exp_ovr;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v, input int idx);
        int nv, nw, nd, bad_a, bad_w, e0, cyc, budget, exp_nv, exp_nw, exp_nd;
        bit done;
        logic [31:0] base, ea;
        string nm;
        nm = $sformatf("vec%0d", idx);
        base = 32'(v.line) * 32'd2048;
        budget = 512 * (v.lat + 6) + 100;
        lat = v.lat;
        e0 = br_err;
        nv = 0; nw = 0; nd = 0; bad_a = 0; bad_w = 0; done = 1'b0;
        repeat (2) @(negedge CLK);
        if (v.pre_fs) begin
            frame_start = 1'b1;
            @(negedge CLK);
            frame_start = 1'b0;
        end
        line_req = 1'b1;
        @(negedge CLK);
        line_req = 1'b0;
        for (cyc = 0; cyc < budget && !done; cyc++) begin
            frame_start = 1'b0;
            line_req = 1'b0;
            if (mem_valid) begin
                if (mem_addr !== base + 32'(nv) * 32'd4) bad_a++;
                if (nv == v.ovr_at) line_req = 1'b1;
                if (nv == v.abort_at) frame_start = 1'b1;
                nv++;
            end
            if (lb_we) begin
                ea = base + 32'(nw) * 32'd4;
                if (lb_waddr !== {v.bank, 9'(nw)} || lb_wdata !== (ea ^ XORK)) bad_w++;
                nw++;
            end
            if (line_done) nd++;
            if (!busy) done = 1'b1;
            else @(negedge CLK);
        end
        frame_start = 1'b0;
        line_req = 1'b0;
        exp_nv = (v.abort_at >= 0) ? v.abort_at + 1 : 512;
        exp_nw = (v.abort_at >= 0) ? v.abort_at : 512;
        exp_nd = (v.abort_at >= 0) ? 0 : 1;
        chk({nm, " finished"}, 64'(done), 64'd1);
        chk({nm, " reads"}, 64'(nv), 64'(exp_nv));
        chk({nm, " bad addr"}, 64'(bad_a), 64'd0);
        chk({nm, " writes"}, 64'(nw), 64'(exp_nw));
        chk({nm, " bad write"}, 64'(bad_w), 64'd0);
        chk({nm, " line_done"}, 64'(nd), 64'(exp_nd));
        chk({nm, " cur_bank"}, 64'(cur_bank), 64'(v.exp_cb));
        chk({nm, " overrun"}, 64'(overrun), 64'(v.exp_ovr));
        chk({nm, " dup reads"}, 64'(br_err - e0), 64'd0);
    endtask

    initial begin
        int k, nw, bad_a, bad_b, to;
        logic [31:0] last_a;

        //          lat fs  ovr  abrt line bank cb ovr
        vecs[0] = '{14, 1'b0, -1,  -1, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{14, 1'b0, -1,  -1, 1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1,  1'b0, -1,  -1, 2, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{3,  1'b0, 200, -1, 3, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1,  1'b0, -1,  -1, 4, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{2,  1'b1, -1,  -1, 0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1,  1'b0, -1,  -1, 1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1,  1'b0, 50,  100, 2, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1,  1'b0, -1,  -1, 0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("reset outputs", 64'(|{mem_valid, mem_addr, mem_wdata, mem_wstrb, lb_we,
            lb_waddr, lb_wdata, busy, line_done, cur_bank, overrun}), 64'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        repeat (2) @(negedge CLK);
        frame_start = 1'b1;
        line_req = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        line_req = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (busy || mem_valid) k++;
            @(negedge CLK);
        end
        chk("fs+req same cycle", 64'(k), 64'd0);
        chk("fs+req overrun", 64'(overrun), 64'd0);

        lat = 14;
        line_req = 1'b1;
        @(negedge CLK);
        line_req = 1'b1;
        @(negedge CLK);
        line_req = 1'b0;
        k = 0;
        nw = 0;
        while (nw < 3 && k < 300) begin
            if (lb_we) nw++;
            if (nw < 3) begin
                @(negedge CLK);
                k++;
            end
        end
        repeat (4) @(negedge CLK);
        chk("pre-reset writes", 64'(nw), 64'd3);
        chk("pre-reset busy/overrun", 64'({busy, overrun}), 64'd3);
        chk("pre-reset addr", 64'(mem_addr), 64'h0000_000C);
        #2 nRST = 1'b0;
        #1;
        chk("async reset outputs", 64'(|{mem_valid, mem_addr, mem_wdata, mem_wstrb, lb_we,
            lb_waddr, lb_wdata, busy, line_done, cur_bank, overrun}), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;

        bad_a = 0;
        bad_b = 0;
        to = 0;
        last_a = 32'hFFFF_FFFF;
        for (int i = 0; i < 601; i++) begin
            @(negedge CLK);
            w_line_req = 1'b1;
            @(negedge CLK);
            w_line_req = 1'b0;
            k = 0;
            while (!w_mem_valid && k < 20) begin
                @(negedge CLK);
                k++;
            end
            if (!w_mem_valid) to++;
            else begin
                if (w_mem_addr !== 32'((i % 600) * 8)) bad_a++;
                if (i == 600) last_a = w_mem_addr;
            end
            k = 0;
            while (!w_line_done && k < 50) begin
                @(negedge CLK);
                k++;
            end
            if (!w_line_done) to++;
            else if (w_cur_bank !== 1'(i % 2)) bad_b++;
            @(negedge CLK);
        end
        chk("wrap timeouts", 64'(to), 64'd0);
        chk("wrap line addr", 64'(bad_a), 64'd0);
        chk("wrap 601st addr", 64'(last_a), 64'd0);
        chk("wrap bank alternation", 64'(bad_b), 64'd0);
        chk("wrap overrun", 64'(w_overrun), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_line_fetch.md
Name: lcd_line_fetch

Overview:
- Line-prefetch DMA between the PSRAM bus bridge (mem_s_* handshake) and the LCD timing generator.
- On each line request it reads one display line of RGB565 pixels (two per 32-bit word) from a PSRAM framebuffer.
- Each word goes into one bank of an external ping-pong line buffer, which the pixel side reads in its own clock domain.
- Runs entirely in the PSRAM user clock, mclk_out.

Parameters:
- FB_BASE, 32'h0000_0000: byte address of line 0 (must be 4-byte aligned).
- WIDTH, 1024: pixels per line (must be even).
- HEIGHT, 600: lines per frame.
- LB_AW, 9: line-buffer word-address width per bank (2**LB_AW >= WIDTH/2).

Ports:
- CLK, input, 1: clock, driven by the PSRAM controller's mclk_out.
- nRST, input, 1: asynchronous active-low reset.
- frame_start, input, 1: single-cycle pulse; restarts at line 0, bank 0, and clears overrun. Already synchronised to CLK.
- line_req, input, 1: single-cycle pulse; fetch the next line. Already synchronised to CLK.
- mem_valid, output, 1: request strobe to the bridge.
- mem_addr, output, 32: byte address.
- mem_wdata, output, 32: tied to 0.
- mem_wstrb, output, 4: tied to 0 (read only).
- mem_rdata, input, 32: read data.
- mem_ready, input, 1: completion level from the bridge.
- lb_we, output, 1: line-buffer write enable.
- lb_waddr, output, LB_AW+1: {bank, word index}.
- lb_wdata, output, 32: pixel pair, with pixel 2k in [15:0] and 2k+1 in [31:16].
- busy, output, 1: a fetch is in progress.
- line_done, output, 1: single-cycle pulse when the last word of a line has been written.
- cur_bank, output, 1: bank most recently completed; the pixel side reads this bank.
- overrun, output, 1: sticky flag, set when line_req arrives while busy.

Behaviour:
- Reset (async): all outputs 0. Internal state: line=0, word=0, wr_bank=0, state=IDLE.
- All outputs are registered.
- Word address: FB_BASE + line*WIDTH*2 + word*4, computed in 32 bits. Words per line W = WIDTH/2.
- Bridge protocol: mem_ready is a level that stays high from the previous completion until the bridge samples the next valid, and the bridge restarts on any valid it sees when idle. Therefore:
  - mem_valid is asserted for exactly one cycle per word.
  - Completion is a low-then-high sequence on mem_ready after that pulse.
- IDLE:
  - On line_req: busy=1, word=0, go to REQ.
  - On frame_start: line=0, wr_bank=0, cur_bank=0, overrun=0.
  - If both arrive in the same cycle, frame_start wins and line_req is dropped.
- REQ: mem_valid=1 and mem_addr valid for one cycle, then go to WAIT_LO.
- WAIT_LO: mem_valid=0. Go to WAIT_HI when mem_ready==0.
- WAIT_HI: when mem_ready==1:
  - Next cycle: lb_we=1 for one cycle, lb_waddr={wr_bank,word}, lb_wdata=mem_rdata captured this cycle.
  - If word==W-1: go to DONE. Otherwise word+1, go to REQ.
  - Minimum of 4 cycles per word (REQ, WAIT_LO, WAIT_HI, write).
- DONE (one cycle):
  - line_done=1, cur_bank=wr_bank, wr_bank toggles, busy=0.
  - line increments; line wraps HEIGHT-1 -> 0. Go to IDLE.
- line_req while busy (including in DONE): dropped, overrun=1 (sticky until frame_start or reset).
- frame_start while busy:
  - Latched as abort. The outstanding word completes (the PSRAM operation cannot be cancelled) but is not written to the buffer.
  - Then line=0, wr_bank=0, cur_bank=0, overrun=0, busy=0, no line_done pulse. Go to IDLE.
- Async reset mid-transaction: immediate return to reset values. The bridge must be reset by the same nRST.
- No timeout: a bridge that never completes hangs the block in a WAIT state. This is visible as busy stuck at 1.

Decomposition:
- Shared package: fetch state encoding (IDLE, REQ, WAIT_LO, WAIT_HI, WR, DONE) and RGB565 field constants (R[15:11], G[10:5], B[4:0]).
- Optional sub-module lcd_fb_addr_gen: line/word counters, wrap logic and the address adder.
- The handshake FSM stays in lcd_line_fetch.

Test Plan:
- Reset, then line_req with a bridge model of 14-cycle latency returning addr^32'hA5A5_A5A5:
  - 512 reads at addresses 0x0 .. 0x7FC.
  - lb_waddr 0..511 in bank 0 with matching data.
  - One line_done pulse, then cur_bank=0.
- Second line_req:
  - Addresses start at 0x800.
  - Writes go to bank 1 (lb_waddr 512..1023).
  - cur_bank=1 after line_done.
- Stale-ready check, with a bridge holding mem_ready=1 from the previous word:
  - Exactly one mem_valid pulse per word, with no duplicate reads.
  - Data is captured only after the ready low-then-high sequence.
- Wrap: issue 600 line_reqs -> the 601st fetch starts at address 0x0 and the bank sequence alternates throughout.
- line_req during a fetch:
  - overrun=1 and the current line completes normally.
  - frame_start clears overrun.
- Abort and reset:
  - frame_start at word 100 -> the outstanding word gets no lb_we, then busy=0, line=0, and there is no line_done.
  - nRST low mid-WAIT_HI -> all outputs 0 immediately.
